// File: rtl/chip2chip_master_control.sv
// Master-side control for the Chip2Chip request/ack/valid link.
// Build option: define ACK_TIMEOUT_EN to abort WAIT_ACK after TIMEOUT_CYCLES and raise a sticky timeout flag.
module chip2chip_master_control #(
  parameter int unsigned CNT_WIDTH      = 27,
  parameter int unsigned NOTICE_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [2:0] data_sw,
  input  logic       ack,
  output logic       request,
  output logic       valid,
  output logic [2:0] data_out,
  output logic       notice,
  output logic       busy,
  output logic       timeout
);

  // state        | meaning
  // IDLE         | waiting for an accepted send pulse
  // WAIT_ACK     | request high, waiting for synchronized ack
  // WAIT_ACK_LOW | valid high with stable data, waiting for ack to drop
  // NOTICE       | transfer done, notice held for NOTICE_CYCLES
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_ACK     = 2'd1,
    WAIT_ACK_LOW = 2'd2,
    NOTICE       = 2'd3
  } state_t;

`ifdef ACK_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0] NOTICE_LAST  = CNT_WIDTH'(NOTICE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 ack_meta_q, ack_s_q;
  logic                 request_q, request_d;
  logic                 valid_q, valid_d;
  logic [2:0]           data_out_q, data_out_d;
  logic                 notice_q, notice_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;

  // Saturate instead of wrapping so a missed compare can never restart the period.
  assign cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    request_d  = request_q;
    valid_d    = valid_q;
    data_out_d = data_out_q;
    notice_d   = notice_q;
    busy_d     = busy_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (send) begin
          data_out_d = data_sw;
          request_d  = 1'b1;
          busy_d     = 1'b1;
          timeout_d  = 1'b0;
          cnt_d      = '0;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        cnt_d = cnt_inc;
        if (ack_s_q) begin
          request_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = WAIT_ACK_LOW;
        end else if (TIMEOUT_EN && (cnt_q >= TIMEOUT_LAST)) begin
          request_d = 1'b0;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      WAIT_ACK_LOW: begin
        if (!ack_s_q) begin
          valid_d  = 1'b0;
          notice_d = 1'b1;
          cnt_d    = '0;
          state_d  = NOTICE;
        end
      end
      NOTICE: begin
        cnt_d = cnt_inc;
        if (cnt_q >= NOTICE_LAST) begin
          notice_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      request_q  <= 1'b0;
      valid_q    <= 1'b0;
      data_out_q <= 3'b000;
      notice_q   <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_meta_q <= ack;
      ack_s_q    <= ack_meta_q;
      request_q  <= request_d;
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
      notice_q   <= notice_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign request  = request_q;
  assign valid    = valid_q;
  assign data_out = data_out_q;
  assign notice   = notice_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_chip2chip_master_control.sv
// Bench for chip2chip_master_control: expected outputs come from the handshake timeline
// (send, ack rise/fall edges) computed arithmetically per transfer.
module tb_chip2chip_master_control;
  localparam int N = 8;
  localparam int T = 32;
  localparam int W = 6;

  logic       clk = 1'b0;
  logic       rst, send, ack;
  logic [2:0] data_sw, data_out;
  logic       request, valid, notice, busy, timeout;

  int checks = 0;
  int errors = 0;
  int xfer_id = 0;

  logic [2:0] exp_data;
  bit         exp_tmo;

  chip2chip_master_control #(
    .CNT_WIDTH(W),
    .NOTICE_CYCLES(N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .send(send),
    .data_sw(data_sw),
    .ack(ack),
    .request(request),
    .valid(valid),
    .data_out(data_out),
    .notice(notice),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pack(input bit r, input bit v, input bit n, input bit b,
                                      input bit t, input logic [2:0] d);
    return {r, v, n, b, t, d};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {request, valid, notice, busy, timeout, data_out};
  endfunction

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = obs_vec();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: {req,val,ntc,busy,tmo,data} got %b expected %b", tag, obs, exp);
    end
  endtask

  // One full transfer: send sampled at edge 1, ack raised after edge a, dropped hold
  // cycles after valid becomes visible. Optional ignored send pulses in each busy state.
  task automatic run_xfer(input logic [2:0] d, input int a, input int hold, input bit inject);
    int f;
    int last;
    f    = a + 3 + hold;
    last = f + 2 + N + 3;
    xfer_id++;
    for (int k = 0; k <= last; k++) begin
      chk($sformatf("xfer%0d_k%0d", xfer_id, k),
          pack(k >= 1 && k <= a + 2,
               k >= a + 3 && k <= f + 2,
               k >= f + 3 && k <= f + 2 + N,
               k >= 1 && k <= f + 2 + N,
               (k == 0) ? exp_tmo : 1'b0,
               (k == 0) ? exp_data : d));
      if (k == a) ack = 1'b1;
      if (k == f) ack = 1'b0;
      if (k == 0) begin
        send    = 1'b1;
        data_sw = d;
      end else if (inject && (k == 2 || k == a + 4 || k == f + 5)) begin
        send    = 1'b1;
        data_sw = 3'b010;
      end else begin
        send    = 1'b0;
        data_sw = 3'($urandom);
      end
      step();
    end
    send     = 1'b0;
    exp_data = d;
    exp_tmo  = 1'b0;
  endtask

  initial begin
    logic [2:0] d;
    rst = 1'b1; send = 1'b1; data_sw = 3'b111; ack = 1'b0;

    // Reset held 3 cycles with send asserted.
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset_hold%0d", i), pack(0, 0, 0, 0, 0, 3'b000));
    end
    rst = 1'b0; send = 1'b0;
    step();
    chk("reset_release", pack(0, 0, 0, 0, 0, 3'b000));
    exp_data = 3'b000;
    exp_tmo  = 1'b0;

    // Directed normal transfer, then same transfer with ignored sends.
    run_xfer(3'b101, 5, 2, 1'b0);
    run_xfer(3'b101, 5, 2, 1'b1);

    // Single-cycle ack glitch while idle.
    ack = 1'b1;
    step();
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("glitch_idle%0d", i), pack(0, 0, 0, 0, exp_tmo, exp_data));
    end

`ifdef ACK_TIMEOUT_EN
    d = 3'($urandom);
    for (int k = 0; k <= T + 3; k++) begin
      chk($sformatf("timeout_k%0d", k),
          pack(k >= 1 && k <= T, 0, 0, k >= 1 && k <= T, k >= T + 1,
               (k == 0) ? exp_data : d));
      send    = (k == 0);
      data_sw = d;
      step();
    end
    send     = 1'b0;
    exp_data = d;
    exp_tmo  = 1'b1;
    run_xfer(3'($urandom), 3, 1, 1'b0);
`else
    d = 3'($urandom);
    for (int k = 0; k <= 1000; k++) begin
      if (k > 0 && k % 100 == 0)
        chk($sformatf("no_timeout_k%0d", k), pack(1, 0, 0, 1, 0, d));
      send    = (k == 0);
      data_sw = d;
      step();
    end
    send = 1'b0;
    rst  = 1'b1;
    step();
    rst = 1'b0;
    chk("no_timeout_reset", pack(0, 0, 0, 0, 0, 3'b000));
    exp_data = 3'b000;
    exp_tmo  = 1'b0;
`endif

    // Randomized transfers.
    for (int i = 0; i < 6; i++)
      run_xfer(3'($urandom), $urandom_range(1, 10), $urandom_range(0, 5), 1'b0);

    // Reset while in WAIT_ACK_LOW, then a normal transfer of 3'b011.
    data_sw = 3'b110; send = 1'b1;
    step();
    send = 1'b0; ack = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pre_reset_valid", pack(0, 1, 0, 1, 0, 3'b110));
    rst = 1'b1;
    step();
    chk("mid_reset", pack(0, 0, 0, 0, 0, 3'b000));
    rst = 1'b0; ack = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("post_reset_idle", pack(0, 0, 0, 0, 0, 3'b000));
    exp_data = 3'b000;
    exp_tmo  = 1'b0;
    run_xfer(3'b011, 4, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chip2chip_master_control.md
Name: chip2chip_master_control

Overview:
- Control block for the master side of the Chip2Chip request/ack/valid link.
- Starts a transfer on a one-cycle send pulse and raises request. After the slave answers with ack, it drives a 3-bit data word with valid and holds valid until ack falls. It then asserts notice for the notice period.
- Sits between the debounced/one-pulsed send button and switches on the master board, and the inter-board wires to the slave control.

Parameters:
- CNT_WIDTH, 27, width of the shared cycle counter. Must hold NOTICE_CYCLES and TIMEOUT_CYCLES.
- NOTICE_CYCLES, 100_000_000, cycles notice stays high after a completed transfer (1 s at 100 MHz).
- TIMEOUT_CYCLES, 100_000_000, cycles spent in WAIT_ACK before abort. Used only with ACK_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- send  in  1  one-cycle pulse requesting a transfer.
- data_sw  in  3  data word to send, sampled on an accepted send.
- ack  in  1  ack from slave; asynchronous to clk.
- request  out  1  request to slave.
- valid  out  1  data_out is valid for the slave to sample.
- data_out  out  3  data to slave.
- notice  out  1  high for NOTICE_CYCLES after a completed transfer.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  sticky abort flag.

Behaviour:
- All outputs are registered. Synchronous reset (rst=1 at posedge) clears all outputs, the counter and the synchronizer, and puts the FSM in IDLE. Reset mid-transfer abandons the transfer immediately, with no handshake completion.
- ack passes through a 2-flop synchronizer; ack_s is the second flop. The FSM uses only ack_s.
- IDLE (state 0):
  - Outputs: request=0, valid=0, busy=0.
  - On send=1: data_out<=data_sw, request<=1, busy<=1, timeout<=0, counter<=0, go to WAIT_ACK.
- WAIT_ACK (1):
  - request=1; the counter increments each cycle.
  - If ack_s=1: request<=0, valid<=1, go to WAIT_ACK_LOW.
  - Otherwise, if the counter is TIMEOUT_CYCLES-1 and ACK_TIMEOUT_EN is defined: request<=0, timeout<=1, go to IDLE.
  - If ack_s and the timeout condition occur in the same cycle, ack wins.
- WAIT_ACK_LOW (2):
  - valid=1; data_out holds stable.
  - When ack_s=0: valid<=0, notice<=1, counter<=0, go to NOTICE.
- NOTICE (3):
  - notice=1; the counter increments each cycle.
  - When the counter is NOTICE_CYCLES-1: notice<=0, busy<=0, go to IDLE.
- send is ignored in every state except IDLE, and is not queued.
- data_out changes only on an accepted send; it holds its value after the transfer.
- Latency:
  - send edge to request high: 1 clk.
  - Edge where ack rises to valid high: 3 clk (2 sync + 1 register), with request dropping on the same edge as valid rises.
  - Edge where ack falls to valid low / notice high: 3 clk.
- request and valid are never high in the same cycle.
- Counter compare uses CNT_WIDTH unsigned arithmetic with no wrap. The counter saturates rather than wrapping if it somehow exceeds the compare value.
- ack glitch in IDLE or NOTICE: ignored, no state change.
- ack falling while in WAIT_ACK before reaching ack_s: no effect.

Optional Feature:
- Macro ACK_TIMEOUT_EN.
- Defined: WAIT_ACK aborts after TIMEOUT_CYCLES as described above, and timeout is a sticky flag cleared on the next accepted send.
- Undefined: WAIT_ACK waits indefinitely for ack_s, timeout is tied to 0, and TIMEOUT_CYCLES is unused.

Test Plan (NOTICE_CYCLES=8, TIMEOUT_CYCLES=32, CNT_WIDTH=6):
1. Reset held 3 cycles, then released -> request, valid, data_out, notice, busy and timeout are all 0; send asserted during rst is ignored.
2. Normal transfer:
   - Stimulus: data_sw=3'b101, send pulse at edge 0; slave model raises ack at edge 5 and drops it 2 cycles after valid is seen.
   - Required: request=1 on edges 1..7 and request=0 / valid=1 at edge 8. data_out=3'b101 while valid=1. valid falls 3 clk after ack falls, then notice is high for exactly 8 cycles, then busy=0.
3. send pulses (data_sw=3'b010) during WAIT_ACK, WAIT_ACK_LOW and NOTICE of a 3'b101 transfer -> ignored; data_out stays 3'b101 and no second request follows.
4. With ACK_TIMEOUT_EN, ack held 0:
   - Stimulus: send, ack never rises.
   - Required: request stays high 32 cycles then falls, timeout=1, FSM returns to IDLE.
   - Follow-up: next send clears timeout and a normal transfer completes. Without the macro, request stays high after 1000 cycles and timeout=0.
5. ack 1-cycle glitch in IDLE -> no output changes.
6. rst asserted while in WAIT_ACK_LOW -> valid=0 on the next edge, FSM in IDLE; a subsequent transfer of 3'b011 completes normally.
